// File: rtl/mole_scheduler_pkg.sv
// Shared constants for the whack-a-mole pipeline: hole geometry, default
// timebase lengths and the scheduler state encoding.
package mole_scheduler_pkg;
  localparam int NUM_HOLES     = 9;
  localparam int HOLE_W        = 4;
  localparam int DEF_UP_TICKS  = 500;
  localparam int DEF_GAP_TICKS = 200;
  localparam int DEF_LIVES     = 3;
  localparam int DEF_SCORE_W   = 8;

  typedef enum logic [2:0] {S_IDLE, S_GAP, S_SPAWN, S_UP, S_OVER} state_e;

  function automatic logic [NUM_HOLES-1:0] hole_onehot(input logic [HOLE_W-1:0] idx);
    hole_onehot = NUM_HOLES'(1) << idx;
  endfunction
endpackage

// File: rtl/mole_scheduler_if.sv
// Game-side bundle between the scheduler and its neighbours (LFSR, keys,
// display/sound). master drives the inputs, slave is the scheduler.
interface mole_scheduler_if import mole_scheduler_pkg::*; #(
  parameter int SCORE_W = DEF_SCORE_W
) ();
  logic                 tick;
  logic                 start;
  logic [HOLE_W-1:0]    rnd_num;
  logic [NUM_HOLES-1:0] whack;
  logic [NUM_HOLES-1:0] mole;
  logic                 hit;
  logic                 miss;
  logic [SCORE_W-1:0]   score;
  logic [1:0]           lives;
  logic                 playing;
  logic                 game_over;

  modport master (
    output tick, start, rnd_num, whack,
    input  mole, hit, miss, score, lives, playing, game_over
  );
  modport slave (
    input  tick, start, rnd_num, whack,
    output mole, hit, miss, score, lives, playing, game_over
  );
endinterface

// File: rtl/mole_scheduler_tick_timer.sv
// Tick counter with synchronous clear; tc fires on the tick that lands on term.
module mole_scheduler_tick_timer #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             tc
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  assign tc = en && (cnt_q == term);

  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
endmodule

// File: rtl/mole_scheduler.sv
// Mole scheduler: spawns a mole per valid random index, times it out, judges
// whacks, and keeps score/lives. All outputs are registered.
module mole_scheduler import mole_scheduler_pkg::*; #(
  parameter int UP_TICKS  = DEF_UP_TICKS,
  parameter int GAP_TICKS = DEF_GAP_TICKS,
  parameter int LIVES     = DEF_LIVES,
  parameter int SCORE_W   = DEF_SCORE_W
) (
  input  logic clk,
  input  logic reset,
  mole_scheduler_if.slave bus
);
  localparam int MAXT  = (UP_TICKS > GAP_TICKS) ? UP_TICKS : GAP_TICKS;
  localparam int CNT_W = (MAXT > 2) ? $clog2(MAXT) : 1;

  state_e               state_q, state_d;
  logic [NUM_HOLES-1:0] mole_q, mole_d;
  logic                 hit_q, hit_d, miss_q, miss_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [1:0]           lives_q, lives_d;
  logic                 playing_q, playing_d, over_q, over_d;
  logic                 lose;
  logic                 tmr_clr, tmr_tc;
  logic [CNT_W-1:0]     tmr_term;

  // One timer serves both GAP and UP; it restarts on every state change.
  assign tmr_term = (state_q == S_UP) ? CNT_W'(UP_TICKS - 1) : CNT_W'(GAP_TICKS - 1);
  assign tmr_clr  = (state_d != state_q) || !(state_q == S_GAP || state_q == S_UP);

  mole_scheduler_tick_timer #(.CNT_W(CNT_W)) u_timer (
    .clk(clk), .reset(reset), .clr(tmr_clr), .en(bus.tick), .term(tmr_term), .tc(tmr_tc)
  );

  always_comb begin
    state_d   = state_q;
    mole_d    = mole_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    score_d   = score_q;
    lives_d   = lives_q;
    playing_d = playing_q;
    over_d    = over_q;
    lose      = 1'b0;
    case (state_q)
      S_IDLE, S_OVER: if (bus.start) begin
        state_d   = S_GAP;
        score_d   = '0;
        lives_d   = 2'(LIVES);
        playing_d = 1'b1;
        over_d    = 1'b0;
        mole_d    = '0;
      end
      S_GAP: if (tmr_tc) state_d = S_SPAWN;
      S_SPAWN: if (bus.rnd_num < HOLE_W'(NUM_HOLES)) begin
        state_d = S_UP;
        mole_d  = hole_onehot(bus.rnd_num);
      end
      S_UP: begin
        // A whack on the timeout tick is judged as a whack.
        if (|bus.whack) begin
          if (|(bus.whack & mole_q)) begin
            hit_d = 1'b1;
            if (score_q != '1) score_d = score_q + 1'b1;
          end else lose = 1'b1;
          mole_d  = '0;
          state_d = S_GAP;
        end else if (tmr_tc) begin
          lose    = 1'b1;
          mole_d  = '0;
          state_d = S_GAP;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (lose) begin
      miss_d  = 1'b1;
      lives_d = lives_q - 2'd1;
      if (lives_q <= 2'd1) begin
        state_d   = S_OVER;
        playing_d = 1'b0;
        over_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= S_IDLE;
      mole_q    <= '0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      score_q   <= '0;
      lives_q   <= 2'(LIVES);
      playing_q <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mole_q    <= mole_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      score_q   <= score_d;
      lives_q   <= lives_d;
      playing_q <= playing_d;
      over_q    <= over_d;
    end

  assign bus.mole      = mole_q;
  assign bus.hit       = hit_q;
  assign bus.miss      = miss_q;
  assign bus.score     = score_q;
  assign bus.lives     = lives_q;
  assign bus.playing   = playing_q;
  assign bus.game_over = over_q;
endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler with short timebase (GAP=2, UP=4 ticks).
module tb_mole_scheduler;
  logic clk, reset;
  int   errs, checks;

  mole_scheduler_if #(.SCORE_W(8)) bus ();

  mole_scheduler #(.UP_TICKS(4), .GAP_TICKS(2), .LIVES(3), .SCORE_W(8)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_tick();
    bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
  endtask

  task automatic do_whack(input logic [8:0] w);
    bus.whack = w; cyc(); bus.whack = '0;
  endtask

  // From GAP with a cleared counter: two ticks to SPAWN, one clk to sample.
  task automatic go_up();
    do_tick(); do_tick(); cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.tick = 0; bus.start = 0; bus.rnd_num = 4'd4; bus.whack = '0;
    cyc(); cyc();
    checks++; if (bus.mole !== 9'h000) begin errs++; $display("FAIL reset_mole got=%h want=000", bus.mole); end
    checks++; if ({bus.hit, bus.miss, bus.playing, bus.game_over} !== 4'b0000) begin errs++; $display("FAIL reset_flags got=%b want=0000", {bus.hit, bus.miss, bus.playing, bus.game_over}); end
    checks++; if (bus.score !== 8'd0 || bus.lives !== 2'd3) begin errs++; $display("FAIL reset_score_lives got=%0d/%0d want=0/3", bus.score, bus.lives); end
    reset = 1'b0; cyc();
  endtask

  task automatic test_hit();
    bus.rnd_num = 4'd4;
    do_start();
    checks++; if (bus.playing !== 1'b1) begin errs++; $display("FAIL start_playing got=%b want=1", bus.playing); end
    do_tick(); do_tick();
    checks++; if (bus.mole !== 9'h000) begin errs++; $display("FAIL gap_no_mole got=%h want=000", bus.mole); end
    cyc();
    checks++; if (bus.mole !== 9'h010) begin errs++; $display("FAIL spawn_mole got=%h want=010", bus.mole); end
    do_whack(9'h010);
    checks++; if ({bus.hit, bus.miss} !== 2'b10 || bus.score !== 8'd1 || bus.mole !== 9'h000) begin errs++; $display("FAIL hit got=hm%b s%0d m%h want=hm10 s1 m000", {bus.hit, bus.miss}, bus.score, bus.mole); end
    cyc();
    checks++; if ({bus.hit, bus.miss} !== 2'b00) begin errs++; $display("FAIL hit_width got=%b want=00", {bus.hit, bus.miss}); end
  endtask

  task automatic test_miss();
    go_up();
    do_whack(9'h001);
    checks++; if ({bus.hit, bus.miss} !== 2'b01 || bus.lives !== 2'd2 || bus.score !== 8'd1 || bus.mole !== 9'h000) begin errs++; $display("FAIL wrong_whack got=hm%b l%0d s%0d m%h want=hm01 l2 s1 m000", {bus.hit, bus.miss}, bus.lives, bus.score, bus.mole); end
  endtask

  task automatic test_timeout();
    go_up();
    do_tick(); do_tick(); do_tick();
    checks++; if (bus.miss !== 1'b0 || bus.mole !== 9'h010) begin errs++; $display("FAIL early_timeout got=miss%b m%h want=miss0 m010", bus.miss, bus.mole); end
    do_tick();
    checks++; if (bus.miss !== 1'b1 || bus.lives !== 2'd1 || bus.mole !== 9'h000) begin errs++; $display("FAIL timeout got=miss%b l%0d m%h want=miss1 l1 m000", bus.miss, bus.lives, bus.mole); end
    // Whack coinciding with the timeout tick wins.
    go_up();
    do_tick(); do_tick(); do_tick();
    bus.tick = 1'b1; bus.whack = 9'h010; cyc(); bus.tick = 1'b0; bus.whack = '0;
    checks++; if ({bus.hit, bus.miss} !== 2'b10 || bus.lives !== 2'd1 || bus.score !== 8'd2) begin errs++; $display("FAIL whack_vs_timeout got=hm%b l%0d s%0d want=hm10 l1 s2", {bus.hit, bus.miss}, bus.lives, bus.score); end
  endtask

  task automatic test_spawn_invalid();
    do_start();
    checks++; if (bus.score !== 8'd2 || bus.lives !== 2'd1) begin errs++; $display("FAIL start_while_playing got=s%0d l%0d want=s2 l1", bus.score, bus.lives); end
    bus.rnd_num = 4'd12;
    do_tick(); do_tick();
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++; if (bus.mole !== 9'h000) begin errs++; $display("FAIL invalid_rnd_%0d got=%h want=000", i, bus.mole); end
    end
    bus.rnd_num = 4'd8; cyc();
    checks++; if (bus.mole !== 9'h100) begin errs++; $display("FAIL hole8 got=%h want=100", bus.mole); end
    do_whack(9'h181);
    checks++; if ({bus.hit, bus.miss} !== 2'b10 || bus.score !== 8'd3) begin errs++; $display("FAIL multi_whack got=hm%b s%0d want=hm10 s3", {bus.hit, bus.miss}, bus.score); end
    bus.rnd_num = 4'd4;
  endtask

  task automatic test_game_over();
    reset = 1'b1; cyc(); reset = 1'b0; cyc();
    do_start();
    go_up(); do_whack(9'h001);
    go_up(); do_tick(); do_tick(); do_tick(); do_tick();
    checks++; if (bus.lives !== 2'd1 || bus.game_over !== 1'b0) begin errs++; $display("FAIL two_misses got=l%0d go%b want=l1 go0", bus.lives, bus.game_over); end
    go_up(); do_whack(9'h002);
    checks++; if ({bus.game_over, bus.playing} !== 2'b10 || bus.mole !== 9'h000 || bus.miss !== 1'b1 || bus.lives !== 2'd0) begin errs++; $display("FAIL game_over got=gp%b m%h miss%b l%0d want=gp10 m000 miss1 l0", {bus.game_over, bus.playing}, bus.mole, bus.miss, bus.lives); end
    do_whack(9'h010); do_tick(); do_tick(); do_tick(); cyc();
    checks++; if ({bus.hit, bus.miss} !== 2'b00 || bus.mole !== 9'h000 || bus.game_over !== 1'b1 || bus.lives !== 2'd0) begin errs++; $display("FAIL over_inert got=hm%b m%h go%b l%0d want=hm00 m000 go1 l0", {bus.hit, bus.miss}, bus.mole, bus.game_over, bus.lives); end
    do_start();
    checks++; if ({bus.game_over, bus.playing} !== 2'b01 || bus.score !== 8'd0 || bus.lives !== 2'd3) begin errs++; $display("FAIL restart got=gp%b s%0d l%0d want=gp01 s0 l3", {bus.game_over, bus.playing}, bus.score, bus.lives); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin go_up(); do_whack(9'h010); end
    go_up();
    checks++; if (bus.mole !== 9'h010 || bus.score !== 8'd5) begin errs++; $display("FAIL pre_reset got=m%h s%0d want=m010 s5", bus.mole, bus.score); end
    reset = 1'b1; #2;
    checks++; if (bus.mole !== 9'h000 || bus.score !== 8'd0 || bus.lives !== 2'd3 || bus.playing !== 1'b0) begin errs++; $display("FAIL async_reset got=m%h s%0d l%0d p%b want=m000 s0 l3 p0", bus.mole, bus.score, bus.lives, bus.playing); end
    bus.whack = 9'h010; cyc(); bus.whack = '0; reset = 1'b0; cyc();
    checks++; if ({bus.hit, bus.miss} !== 2'b00 || bus.mole !== 9'h000) begin errs++; $display("FAIL reset_no_pulse got=hm%b m%h want=hm00 m000", {bus.hit, bus.miss}, bus.mole); end
  endtask

  initial begin
    errs = 0; checks = 0;
    test_reset();
    test_hit();
    test_miss();
    test_timeout();
    test_spawn_invalid();
    test_game_over();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mole_scheduler.md
Name: mole_scheduler

Overview:
- Downstream consumer of the 0–8 random hole index produced by the LFSR stage.
- Turns each accepted index into a timed "mole up" event on one of 9 holes and judges player whacks as hit or miss.
- Maintains score and remaining lives, and drives the one-hot hole LEDs plus hit/miss pulses to the display and sound stages.
- Advances on a shared timebase tick, not on raw clock counts.

Parameters:
- UP_TICKS, 500, ticks a mole stays up before it counts as a miss.
- GAP_TICKS, 200, ticks of empty board between moles.
- LIVES, 3, misses allowed before game over.
- SCORE_W, 8, score counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tick  in  1  single-cycle timebase enable (e.g. 1 ms)
- start  in  1  single-cycle pulse, begins a game
- rnd_num  in  4  random hole index from LFSR stage, held between updates
- whack  in  9  synchronised, debounced single-cycle key pulses, bit i = hole i
- mole  out  9  one-hot hole currently up, all zero when none
- hit  out  1  one-cycle pulse on a correct whack
- miss  out  1  one-cycle pulse on a wrong whack or a timeout
- score  out  SCORE_W  hits this game, saturating
- lives  out  2  remaining lives
- playing  out  1  high while a game is in progress
- game_over  out  1  high from last life lost until next start

Behaviour:
- Reset (async, active-high) values: state IDLE; mole=0, hit=0, miss=0, score=0, lives=LIVES, playing=0, game_over=0; tick counter=0.
- States: IDLE, GAP, SPAWN, UP, OVER.
- IDLE:
  - start → GAP; score=0; lives=LIVES; counter=0; playing=1.
- GAP:
  - Counter increments on tick.
  - When counter==GAP_TICKS-1 and tick → SPAWN; counter=0.
  - Whacks here are ignored (no penalty).
- SPAWN:
  - Sample rnd_num each clk.
  - If rnd_num<=8 → UP; mole=1<<rnd_num.
  - If rnd_num>8, stay in SPAWN and resample next clk; no timeout.
  - Latency start→mole is GAP_TICKS ticks + ≥1 clk.
- UP:
  - Counter increments on tick.
  - If whack has any bit set:
    - whack & mole nonzero → hit pulse; score+1, saturating at all ones.
    - Otherwise → miss pulse; lives-1.
    - In either case mole=0, counter=0, → GAP (or OVER if lives reaches 0).
  - Timeout (counter==UP_TICKS-1 and tick, no whack that cycle) → miss; lives-1; same exit.
  - Whack and timeout in the same cycle: the whack wins and is judged as above.
  - Multiple whack bits that include the mole bit count as a hit.
- OVER:
  - playing=0; game_over=1; mole=0.
  - start → same as start from IDLE; game_over=0 on the next clk.
- start while playing is ignored.
- hit and miss are each exactly 1 clk wide; never both in the same cycle.
- Outputs are registered; mole updates on the clk edge following the decision.
- Reset asserted mid-game: immediately returns everything to reset values; no pulses emitted.

Decomposition:
- Shared package (game_pkg):
  - state encoding constants.
  - NUM_HOLES=9.
  - Hole index width = 4.
  - Default tick constants, shared with the LFSR and display stages.
- One natural sub-module: tick_timer — loadable tick counter with terminal-count flag, reused for GAP and UP.
- Scoring and lives stay inline.

Test Plan:
- reset high mid-UP with mole=9'h010, score=5 → next cycle mole=0, score=0, lives=3, playing=0, no hit/miss pulse.
- start, rnd_num=4, GAP_TICKS=2, UP_TICKS=4 → mole=9'h010 after 2 ticks + 1 clk; whack=9'h010 → hit one clk, score=1, mole=0, state GAP.
- Mole on hole 4, whack=9'h001 → miss pulse, lives 3→2, no score change.
- No whack for UP_TICKS ticks → miss on the 4th tick; lives-1; whack on that same cycle at the mole bit → hit instead, lives unchanged.
- rnd_num held at 4'd12 for 5 clks then 4'd8 → no mole during invalid values; then mole=9'h100.
- Three consecutive misses → game_over=1, playing=0, mole=0; further whacks have no effect; start → score=0, lives=3, game_over=0.
